// File: rtl/dma_read_agu.sv
// Read-side DMA address generator: two-level strided read loop feeding local memory.
// Optional DMA_AGU_STALL_CNT_EN adds a saturating stall_cnt output.
module dma_read_agu #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int CNT_W      = 16,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  run,
  input  logic                  valid,
  input  logic [2:0]            addr,
  input  logic [ADDR_W-1:0]     wdata,
  input  logic                  wstrb,
  output logic                  databus_valid,
  output logic [ADDR_W-1:0]     databus_addr,
  input  logic [DATA_W-1:0]     databus_rdata,
  input  logic                  databus_ready,
  output logic                  mem_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  done
`ifdef DMA_AGU_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] BYTES = ADDR_W'(DATA_W / 8);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]     ext_q;
  logic [MEM_ADDR_W-1:0] int_q;
  logic [CNT_W-1:0]      iter_q, per_q, shift_q, incr_q;

  logic [CNT_W-1:0]      sh_iter_q, sh_iter_d;
  logic [CNT_W-1:0]      sh_per_q, sh_per_d;
  logic [ADDR_W-1:0]     sh_shift_q, sh_shift_d;
  logic [ADDR_W-1:0]     sh_incr_q, sh_incr_d;

  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [CNT_W-1:0]      p_q, p_d;
  logic [CNT_W-1:0]      i_q, i_d;
  logic [MEM_ADDR_W-1:0] wptr_q, wptr_d;
  logic                  mem_en_q, mem_en_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

  logic last_p, last_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_q   <= '0;
      int_q   <= '0;
      iter_q  <= '0;
      per_q   <= '0;
      shift_q <= '0;
      incr_q  <= '0;
    end else if (clear) begin
      ext_q   <= '0;
      int_q   <= '0;
      iter_q  <= '0;
      per_q   <= '0;
      shift_q <= '0;
      incr_q  <= '0;
    end else if (valid && wstrb) begin
      unique case (addr)
        3'd0: ext_q   <= wdata;
        3'd1: int_q   <= wdata[MEM_ADDR_W-1:0];
        3'd2: iter_q  <= wdata[CNT_W-1:0];
        3'd3: per_q   <= wdata[CNT_W-1:0];
        3'd4: shift_q <= wdata[CNT_W-1:0];
        3'd5: incr_q  <= wdata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  assign last_p = (p_q == sh_per_q - CNT_W'(1));
  assign last_i = (i_q == sh_iter_q - CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    sh_iter_d   = sh_iter_q;
    sh_per_d    = sh_per_q;
    sh_shift_d  = sh_shift_q;
    sh_incr_d   = sh_incr_q;
    addr_d      = addr_q;
    base_d      = base_q;
    p_d         = p_q;
    i_d         = i_q;
    wptr_d      = wptr_q;
    mem_en_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          sh_iter_d  = iter_q;
          sh_per_d   = per_q;
          sh_shift_d = ADDR_W'(shift_q) * BYTES;
          sh_incr_d  = ADDR_W'(incr_q) * BYTES;
          addr_d     = ext_q;
          base_d     = ext_q;
          p_d        = '0;
          i_d        = '0;
          wptr_d     = int_q;
          if (iter_q != '0 && per_q != '0)
            state_d = REQ;
        end
      end
      REQ: begin
        if (databus_ready) begin
          mem_en_d    = 1'b1;
          mem_wdata_d = databus_rdata;
          mem_addr_d  = wptr_q;
          wptr_d      = wptr_q + MEM_ADDR_W'(1);
          if (last_p) begin
            if (last_i) begin
              state_d = IDLE;
            end else begin
              p_d    = '0;
              i_d    = i_q + CNT_W'(1);
              base_d = base_q + sh_shift_q;
              addr_d = base_q + sh_shift_q;
            end
          end else begin
            p_d    = p_q + CNT_W'(1);
            addr_d = addr_q + sh_incr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sh_iter_q   <= '0;
      sh_per_q    <= '0;
      sh_shift_q  <= '0;
      sh_incr_q   <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      p_q         <= '0;
      i_q         <= '0;
      wptr_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sh_iter_q   <= sh_iter_d;
      sh_per_q    <= sh_per_d;
      sh_shift_q  <= sh_shift_d;
      sh_incr_q   <= sh_incr_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      p_q         <= p_d;
      i_q         <= i_d;
      wptr_q      <= wptr_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign databus_valid = (state_q == REQ);
  assign databus_addr  = addr_q;
  assign done          = (state_q == IDLE);
  assign mem_en        = mem_en_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

`ifdef DMA_AGU_STALL_CNT_EN
  logic [31:0] stall_q;

  // Only an accepted run (from IDLE) restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_q <= '0;
    else if (state_q == IDLE && run)
      stall_q <= '0;
    else if (state_q == REQ && !databus_ready && stall_q != '1)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dma_read_agu.sv
// Bench for dma_read_agu: loop-point reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_dma_read_agu;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int CW = 16;
  localparam int MW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          run = 1'b0;
  logic          valid = 1'b0;
  logic          wstrb = 1'b0;
  logic [2:0]    addr = '0;
  logic [AW-1:0] wdata = '0;
  logic          databus_valid;
  logic [AW-1:0] databus_addr;
  logic [DW-1:0] databus_rdata = '0;
  logic          databus_ready = 1'b0;
  logic          mem_en;
  logic [MW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          done;
`ifdef DMA_AGU_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  dma_read_agu #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .MEM_ADDR_W(MW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .run(run),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .databus_valid(databus_valid), .databus_addr(databus_addr),
    .databus_rdata(databus_rdata), .databus_ready(databus_ready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done)
`ifdef DMA_AGU_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model state
  logic [AW-1:0]   cfg [6];
  bit              busy;
  logic [AW-1:0]   q_addr [$];
  logic [MW-1:0]   wptr;
  longint unsigned mstall;
  bit              em;
  logic [MW-1:0]   ema;
  logic [DW-1:0]   emd;
  logic [AW-1:0]   prev_addr;

  // observation logs
  logic [AW-1:0]   acc_log [$];
  logic [MW-1:0]   mlog_a [$];
  logic [DW-1:0]   mlog_d [$];
  logic [DW-1:0]   rd_log [$];
  int              valid_cycles;

  function automatic logic [AW-1:0] fmask(input int a);
    case (a)
      0: return 32'hFFFF_FFFF;
      1: return 32'h0000_03FF;
      default: return 32'h0000_FFFF;
    endcase
  endfunction

  task automatic build_points();
    longint unsigned t;
    q_addr.delete();
    for (longint unsigned i = 0; i < cfg[2]; i++)
      for (longint unsigned p = 0; p < cfg[3]; p++) begin
        t = cfg[0] + (i * cfg[4] + p * cfg[5]) * (DW / 8);
        q_addr.push_back(t[AW-1:0]);
      end
  endtask

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      for (int k = 0; k < 6; k++) cfg[k] = '0;
      busy = 0;
      q_addr.delete();
      wptr = '0;
      mstall = 0;
      chk("rst_valid", databus_valid, 0);
      chk("rst_addr", databus_addr, 0);
      chk("rst_done", done, 1);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
`ifdef DMA_AGU_STALL_CNT_EN
      chk("rst_stall", stall_cnt, 0);
`endif
    end else begin
      em = 0;
      if (busy) begin
        if (databus_ready) begin
          acc_log.push_back(prev_addr);
          rd_log.push_back(databus_rdata);
          em  = 1;
          ema = wptr;
          emd = databus_rdata;
          wptr = wptr + 1'b1;
          void'(q_addr.pop_front());
          if (q_addr.size() == 0) busy = 0;
        end else if (mstall != 64'hFFFF_FFFF) begin
          mstall++;
        end
      end else if (run) begin
        mstall = 0;
        build_points();
        wptr = cfg[1][MW-1:0];
        busy = (q_addr.size() != 0);
      end
      if (clear)
        for (int k = 0; k < 6; k++) cfg[k] = '0;
      else if (valid && wstrb && addr < 3'd6)
        cfg[addr] = wdata & fmask(int'(addr));
      chk("valid", databus_valid, busy);
      if (busy) chk("addr", databus_addr, q_addr[0]);
      chk("done", done, !busy);
      chk("mem_en", mem_en, em);
      if (em) begin
        chk("mem_addr", mem_addr, ema);
        chk("mem_wdata", mem_wdata, emd);
      end
      if (mem_en) begin
        mlog_a.push_back(mem_addr);
        mlog_d.push_back(mem_wdata);
      end
`ifdef DMA_AGU_STALL_CNT_EN
      chk("stall", stall_cnt, mstall[31:0]);
`endif
      if (databus_valid) valid_cycles++;
    end
    prev_addr = databus_addr;
  end

  // stimulus
  int mode = 0;
  int ph = 0;

  task automatic cyc();
    @(negedge clk);
    valid = 0;
    wstrb = 0;
    run = 0;
    clear = 0;
    databus_rdata = {8{$urandom}};
    case (mode)
      0: databus_ready = 1'b1;
      1: databus_ready = (ph == 2);
      default: databus_ready = 1'($urandom_range(0, 1));
    endcase
    ph = (ph + 1) % 3;
  endtask

  task automatic wr(input logic [2:0] a, input logic [AW-1:0] d);
    cyc();
    valid = 1;
    wstrb = 1;
    addr = a;
    wdata = d;
  endtask

  task automatic cfg6(input logic [AW-1:0] e, input logic [AW-1:0] ia,
                      input logic [AW-1:0] it, input logic [AW-1:0] pe,
                      input logic [AW-1:0] sh, input logic [AW-1:0] inc);
    wr(0, e);
    wr(1, ia);
    wr(2, it);
    wr(3, pe);
    wr(4, sh);
    wr(5, inc);
  endtask

  task automatic go();
    cyc();
    run = 1;
    ph = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    cyc();
    while (done !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    if (done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL timeout: done=%0b after %0d cycles, want 1", done, n);
    end
  endtask

  task automatic clr_logs();
    acc_log.delete();
    mlog_a.delete();
    mlog_d.delete();
    rd_log.delete();
    valid_cycles = 0;
  endtask

  logic [AW-1:0] exp_a [6];
  logic [MW-1:0] exp_w [4];

  initial begin
    exp_a = '{32'h1000, 32'h1020, 32'h1040, 32'h1080, 32'h10A0, 32'h10C0};
    exp_w = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    valid_cycles = 0;
    repeat (3) cyc();
    rst = 1;
    repeat (2) cyc();

    // strided burst, ready every cycle
    mode = 0;
    cfg6(32'h1000, 5, 2, 3, 4, 1);
    clr_logs();
    go();
    wait_idle(50);
    cyc();
    chk("s_count", acc_log.size(), 6);
    for (int k = 0; k < 6 && k < acc_log.size(); k++)
      chk("s_addr", acc_log[k], exp_a[k]);
    for (int k = 0; k < 6 && k < mlog_a.size(); k++)
      chk("s_maddr", mlog_a[k], MW'(5 + k));
    for (int k = 0; k < mlog_d.size() && k < rd_log.size(); k++)
      chk("s_data", mlog_d[k], rd_log[k]);

    // backpressure, ready every 3rd cycle
    mode = 1;
    clr_logs();
    go();
    wait_idle(100);
    cyc();
    chk("b_count", acc_log.size(), 6);
    for (int k = 0; k < 6 && k < acc_log.size(); k++)
      chk("b_addr", acc_log[k], exp_a[k]);
    for (int k = 0; k < 6 && k < mlog_a.size(); k++)
      chk("b_maddr", mlog_a[k], MW'(5 + k));
`ifdef DMA_AGU_STALL_CNT_EN
    chk("b_stall", stall_cnt, 12);
`endif

    // degenerate
    mode = 0;
    wr(2, 0);
    wr(3, 7);
    cyc();
    clr_logs();
    go();
    repeat (10) cyc();
    chk("d_valid", valid_cycles, 0);
    chk("d_mem", mlog_a.size(), 0);
    chk("d_done", done, 1);

    // re-run and clear mid-transfer
    mode = 1;
    cfg6(32'h2000, 20, 3, 4, 2, 1);
    clr_logs();
    go();
    repeat (5) cyc();
    wr(2, 1);
    cyc();
    run = 1;
    repeat (3) cyc();
    cyc();
    clear = 1;
    wait_idle(200);
    cyc();
    chk("r_count", acc_log.size(), 12);
    if (acc_log.size() == 12) chk("r_last", acc_log[11], 32'h20E0);
    clr_logs();
    go();
    repeat (8) cyc();
    chk("r_zero", valid_cycles, 0);

    // memory address wrap
    mode = 0;
    cfg6(0, 32'h3FE, 1, 4, 0, 1);
    clr_logs();
    go();
    wait_idle(50);
    cyc();
    chk("w_count", mlog_a.size(), 4);
    for (int k = 0; k < 4 && k < mlog_a.size(); k++)
      chk("w_maddr", mlog_a[k], exp_w[k]);

    // reset during second request
    mode = 1;
    cfg6(32'h4000, 0, 2, 3, 1, 1);
    clr_logs();
    go();
    for (int n = 0; n < 20 && acc_log.size() < 1; n++) cyc();
    chk("x_first", acc_log.size(), 1);
    cyc();
    #2 rst = 0;
    #1;
    chk("x_valid", databus_valid, 0);
    chk("x_done", done, 1);
    repeat (3) cyc();
    rst = 1;
    mode = 0;
    valid_cycles = 0;
    repeat (10) cyc();
    chk("x_idle", valid_cycles, 0);

    // randomized loops
    for (int r = 0; r < 25; r++) begin
      mode = $urandom_range(0, 2);
      cfg6($urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
           $urandom, $urandom);
      wr(3'($urandom_range(6, 7)), $urandom);
      go();
      wait_idle(400);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dma_read_agu.md
Name: dma_read_agu

Overview:
- Read-side address generator and return-data sink that masters one read databus port of the DMA.
- Software programs a two-level loop: external base, iterations, period, shift and increment.
- On run, the block issues one databus read per loop point, in order.
- Each returned MIG-bus word is written into a local memory port at consecutive internal addresses.
- Software programs the DMA read-length register to ITER*PER-1 so bursts match the request stream.

Parameters:
ADDR_W, 32, external byte-address width (IO_ADDR_W)
DATA_W, 256, databus word width (MIG_BUS_W); byte stride unit is DATA_W/8
CNT_W, 16, width of ITER, PER, SHIFT, INCR and the loop counters
MEM_ADDR_W, 10, local memory address width

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
clear  input  1  synchronous clear of configuration registers
run  input  1  single-cycle start pulse
valid  input  1  config write strobe
addr  input  3  config register select: 0 EXT_ADDR, 1 INT_ADDR, 2 ITER, 3 PER, 4 SHIFT, 5 INCR
wdata  input  ADDR_W  config write data; fields narrower than ADDR_W take the LSBs
wstrb  input  1  write enable; a config write needs valid&wstrb
databus_valid  output  1  read request
databus_addr  output  ADDR_W  request byte address
databus_rdata  input  DATA_W  returned data, valid in the databus_ready cycle
databus_ready  input  1  request accepted and data returned
mem_en  output  1  local memory write enable
mem_addr  output  MEM_ADDR_W  local memory address
mem_wdata  output  DATA_W  local memory write data
done  output  1  high when idle

Behaviour:
- Reset (rst=0, async) drives the following; all loop state returns to IDLE:
  - databus_valid=0, databus_addr=0
  - mem_en=0, mem_addr=0, mem_wdata=0
  - done=1
  - config and shadow registers = 0
- clear zeroes the config registers only. It does not affect shadows or an operation in flight.
- Config writes and clear are allowed at any time. Writes in the same cycle as run are ignored, because shadows take the pre-edge values.
- States:
  - IDLE: done=1, databus_valid=0. On run, copy all config registers into shadows.
    - If ITER==0 or PER==0: stay IDLE, no requests.
    - Otherwise go to REQ at the next edge with databus_valid=1 and databus_addr=EXT_ADDR.
  - REQ: done=0, databus_valid held high and databus_addr held stable until databus_ready.
    - On each databus_ready, capture databus_rdata and advance the counters p (inner, 0..PER-1) and i (outer, 0..ITER-1).
    - Not last point: databus_addr updates at the next edge, and databus_valid stays high with no bubble.
    - Last point (i=ITER-1, p=PER-1): databus_valid=0 and done=1 at the next edge; return to IDLE.
- Address arithmetic (byte addresses, modulo 2^ADDR_W, unsigned):
  - Inner step: addr += INCR*(DATA_W/8).
  - Inner wrap: iter_base += SHIFT*(DATA_W/8), addr = new iter_base.
  - Products are computed at full ADDR_W width.
- Memory write:
  - mem_en pulses for exactly one cycle, the cycle after each databus_ready.
  - mem_wdata = the captured rdata.
  - mem_addr = INT_ADDR + k for the k-th return, wrapping modulo 2^MEM_ADDR_W.
  - The final mem_en pulse coincides with done rising.
- run while REQ: ignored. Shadows are unchanged and the sequence continues.
- databus_ready while databus_valid=0: ignored.
- Counters are CNT_W wide. Maximum transfer is (2^CNT_W-1)^2 words.

Optional Feature:
DMA_AGU_STALL_CNT_EN:
- When defined, adds output stall_cnt [31:0].
- stall_cnt counts cycles with databus_valid=1 and databus_ready=0.
- It is cleared to 0 on run and on reset, and saturates at 0xFFFFFFFF.
- When undefined, the port and counter are absent and the rest of the behaviour is identical.

Test Plan:
- Strided burst: DATA_W=256; EXT_ADDR=0x1000, INT_ADDR=5, ITER=2, PER=3, SHIFT=4, INCR=1; ready each cycle.
  -> addresses 0x1000, 0x1020, 0x1040, 0x1080, 0x10A0, 0x10C0 on consecutive cycles.
  -> mem_addr 5..10 with rdata matching request order.
  -> done=1 one cycle after the last ready, in the same cycle as the final mem_en.
- Backpressure: ready asserted every 3rd cycle, same config.
  -> databus_addr stable while waiting; identical address/data sequence.
  -> stall_cnt=12 (12 non-ready valid cycles, with _EN defined).
- Degenerate: ITER=0, PER=7, run.
  -> databus_valid never asserts, done stays 1, no mem_en.
- Re-run and clear: run pulsed mid-transfer and clear asserted mid-transfer.
  -> sequence completes unchanged using the original shadows.
  -> a following run with zeroed config produces no requests.
- Wrap: MEM_ADDR_W=10, INT_ADDR=0x3FE, PER=4, ITER=1 -> mem_addr 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-operation: rst=0 during the second request.
  -> databus_valid=0 and done=1 immediately (async).
  -> after release, no requests until a new run.
